core_run_controller: RTL and testbench
======================================

Name: core_run_controller

Overview:
Synthesizable run-control block between the board/bench reset and the RISC-V core top.
- Stretches the incoming reset into a parametrised core reset window.
- Counts cycles and retired instructions while the core runs.
- Ends the run on ecall, PC stall, external stop or cycle timeout, then freezes the core and reports the cause and statistics.

Parameters:
RESET_CYCLES, 2, cycles core_rst stays high after rst deasserts (minimum 1)
MAX_CYCLES, 10000, RUN-cycle budget before timeout (minimum 1)
STALL_LIMIT, 16, consecutive RUN cycles with an unchanged PC that declare a stall halt (minimum 1)
CNT_W, 32, width of cycle and instret counters
PC_W, 32, program-counter width

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
pc_i  input  PC_W  current fetch PC from core
retire_i  input  1  one instruction retired this cycle
ecall_i  input  1  core executed ecall/ebreak this cycle
ext_stop_i  input  1  external stop request
core_rst  output  1  reset to core, active-high
running  output  1  state is RUN
done  output  1  run finished; sticky until rst
halt_cause  output  3  000 none, 001 ecall, 010 pc stall, 011 ext stop, 100 timeout
cycle_count  output  CNT_W  RUN cycles elapsed
instret_count  output  CNT_W  instructions retired in RUN

Behaviour:
- States: HOLD, RUN, DONE. All outputs are registered.
- rst=1 at an edge forces the following next cycle, from any state, including mid-RUN:
  - state=HOLD, hold_cnt=0;
  - core_rst=1, running=0, done=0, halt_cause=000;
  - cycle_count=0, instret_count=0, stall_cnt=0, last_pc=0.
- HOLD (rst=0):
  - hold_cnt increments each edge.
  - At the edge where hold_cnt==RESET_CYCLES-1, state goes to RUN, core_rst=0 and running=1.
  - core_rst is therefore high for exactly RESET_CYCLES edges after rst falls.
  - pc_i, retire_i, ecall_i and ext_stop_i are ignored in HOLD.
- RUN, counters:
  - cycle_count increments by 1 each cycle and saturates at all-ones.
  - instret_count increments when retire_i=1 and saturates.
- RUN, stall detection:
  - First RUN cycle: last_pc<=pc_i, no comparison.
  - Thereafter: pc_i==last_pc gives stall_cnt+1, otherwise stall_cnt=0; last_pc<=pc_i every cycle.
- RUN, halt conditions evaluated in the current cycle:
  - E: ext_stop_i=1
  - C: ecall_i=1
  - S: pc_i==last_pc and stall_cnt==STALL_LIMIT-1 (not in first RUN cycle)
  - T: cycle_count==MAX_CYCLES-1
- Priority when several conditions coincide: E > C > S > T.
- If any condition holds, the next edge sets:
  - state=DONE, done=1, running=0, core_rst=1 (freezes the core);
  - halt_cause per winning condition.
- The halting cycle is counted in cycle_count and in instret_count (if retire_i=1). The timeout therefore ends with cycle_count=MAX_CYCLES.
- DONE:
  - All outputs hold and inputs are ignored.
  - The only exit is rst=1.
- Counter saturation never wraps; with default widths, saturation is unreachable before timeout.

Test Plan:
All scenarios use RESET_CYCLES=2, MAX_CYCLES=20, STALL_LIMIT=4, and count RUN cycles from 1.
1. Reset release:
   - Stimulus: rst=1 for 3 edges, then 0.
   - Required: core_rst=1 for 2 more edges; running=1 and core_rst=0 after the 2nd edge; both counters 0.
2. Timeout:
   - Stimulus: pc 0,4,8,… incrementing; retire_i=1 every cycle; no events.
   - Required: done=1, halt_cause=100, cycle_count=20, instret_count=20, core_rst=1; values stable for 10 further cycles.
3. PC stall:
   - Stimulus: pc 0,4,8,12,16, then held at 16.
   - Required: equality in cycles 6–9 gives done, halt_cause=010, cycle_count=9.
   - Variant: a changing PC at cycle 8 (pc=20) resets stall_cnt, and the stall then fires at cycle 12.
4. Priority:
   - Stimulus: ecall_i=1 and ext_stop_i=1 both in cycle 7.
   - Required: halt_cause=011, cycle_count=7.
   - Variant: ecall_i=1 alone in cycle 20 gives halt_cause=001, not 100.
5. Mid-run reset:
   - Stimulus: rst=1 at cycle 10.
   - Required: next cycle all counters 0, done=0, core_rst=1, state HOLD.
   - Required on release: the full sequence of scenario 1 repeats, and a new run times out at cycle_count=20.
6. Inputs ignored outside RUN:
   - Stimulus: retire_i=1, ecall_i=1 and ext_stop_i=1 during HOLD and during DONE.
   - Required: no counter change, halt_cause unchanged, done unchanged.

Source files
------------

// File: rtl/core_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : core_run_controller
//  Description : Run controller that sits between the bench reset and the
//                core. It stretches the reset into a core reset window,
//                counts run cycles and retired instructions, ends the run on
//                ecall, PC stall, external stop or timeout, and then freezes
//                the core while it reports the halt cause and statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_run_controller #(
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 10000,
    parameter int STALL_LIMIT  = 16,
    parameter int CNT_W        = 32,
    parameter int PC_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             retire_i,
    input  logic             ecall_i,
    input  logic             ext_stop_i,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    // Counter widths sized so the terminal values always fit.
    localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [HOLD_W-1:0]  c_hold_last  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  c_hold_one   = HOLD_W'(1);
    localparam logic [STALL_W-1:0] c_stall_last = STALL_W'(STALL_LIMIT - 1);
    localparam logic [STALL_W-1:0] c_stall_one  = STALL_W'(1);
    localparam logic [CNT_W-1:0]   c_cyc_last   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_cnt_one    = CNT_W'(1);

    localparam logic [2:0] c_cause_none    = 3'b000;
    localparam logic [2:0] c_cause_ecall   = 3'b001;
    localparam logic [2:0] c_cause_stall   = 3'b010;
    localparam logic [2:0] c_cause_ext     = 3'b011;
    localparam logic [2:0] c_cause_timeout = 3'b100;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [HOLD_W-1:0]  w_hold_cnt_nxt;
    logic               r_first;
    logic               w_first_nxt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic [STALL_W-1:0] w_stall_cnt_nxt;
    logic [PC_W-1:0]    r_last_pc;
    logic [PC_W-1:0]    w_last_pc_nxt;
    logic               r_core_rst;
    logic               w_core_rst_nxt;
    logic               r_running;
    logic               w_running_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [2:0]         r_halt_cause;
    logic [2:0]         w_halt_cause_nxt;
    logic [CNT_W-1:0]   r_cycle_count;
    logic [CNT_W-1:0]   w_cycle_count_nxt;
    logic [CNT_W-1:0]   r_instret_count;
    logic [CNT_W-1:0]   w_instret_count_nxt;

    // Halt condition terms, only meaningful while in RUN.
    logic w_pc_same;
    logic w_hit_ext;
    logic w_hit_ecall;
    logic w_hit_stall;
    logic w_hit_timeout;

    assign w_pc_same     = (pc_i == r_last_pc);
    assign w_hit_ext     = ext_stop_i;
    assign w_hit_ecall   = ecall_i;
    // The first RUN cycle has no valid previous PC, so it never counts as a stall.
    assign w_hit_stall   = !r_first && w_pc_same && (r_stall_cnt == c_stall_last);
    assign w_hit_timeout = (r_cycle_count == c_cyc_last);

    // State and output registers; reset wins from any state, including mid-run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_HOLD;
            r_hold_cnt      <= '0;
            r_first         <= 1'b0;
            r_stall_cnt     <= '0;
            r_last_pc       <= '0;
            r_core_rst      <= 1'b1;
            r_running       <= 1'b0;
            r_done          <= 1'b0;
            r_halt_cause    <= c_cause_none;
            r_cycle_count   <= '0;
            r_instret_count <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_hold_cnt      <= w_hold_cnt_nxt;
            r_first         <= w_first_nxt;
            r_stall_cnt     <= w_stall_cnt_nxt;
            r_last_pc       <= w_last_pc_nxt;
            r_core_rst      <= w_core_rst_nxt;
            r_running       <= w_running_nxt;
            r_done          <= w_done_nxt;
            r_halt_cause    <= w_halt_cause_nxt;
            r_cycle_count   <= w_cycle_count_nxt;
            r_instret_count <= w_instret_count_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        w_state_nxt         = r_state;
        w_hold_cnt_nxt      = r_hold_cnt;
        w_first_nxt         = r_first;
        w_stall_cnt_nxt     = r_stall_cnt;
        w_last_pc_nxt       = r_last_pc;
        w_core_rst_nxt      = r_core_rst;
        w_running_nxt       = r_running;
        w_done_nxt          = r_done;
        w_halt_cause_nxt    = r_halt_cause;
        w_cycle_count_nxt   = r_cycle_count;
        w_instret_count_nxt = r_instret_count;

        case (r_state)
            ST_HOLD: begin
                w_hold_cnt_nxt = r_hold_cnt + c_hold_one;
                if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt    = ST_RUN;
                    w_core_rst_nxt = 1'b0;
                    w_running_nxt  = 1'b1;
                    w_first_nxt    = 1'b1;
                end
            end

            ST_RUN: begin
                // Counters saturate rather than wrap.
                if (r_cycle_count != '1) begin
                    w_cycle_count_nxt = r_cycle_count + c_cnt_one;
                end
                if (retire_i && (r_instret_count != '1)) begin
                    w_instret_count_nxt = r_instret_count + c_cnt_one;
                end

                w_last_pc_nxt = pc_i;
                if (r_first) begin
                    w_first_nxt = 1'b0;
                end else if (w_pc_same) begin
                    w_stall_cnt_nxt = r_stall_cnt + c_stall_one;
                end else begin
                    w_stall_cnt_nxt = '0;
                end

                if (w_hit_ext || w_hit_ecall || w_hit_stall || w_hit_timeout) begin
                    w_state_nxt    = ST_DONE;
                    w_done_nxt     = 1'b1;
                    w_running_nxt  = 1'b0;
                    w_core_rst_nxt = 1'b1;
                    if (w_hit_ext) begin
                        w_halt_cause_nxt = c_cause_ext;
                    end else if (w_hit_ecall) begin
                        w_halt_cause_nxt = c_cause_ecall;
                    end else if (w_hit_stall) begin
                        w_halt_cause_nxt = c_cause_stall;
                    end else begin
                        w_halt_cause_nxt = c_cause_timeout;
                    end
                end
            end

            ST_DONE: begin
                // Frozen until the next reset.
            end

            default: begin
                w_state_nxt    = ST_HOLD;
                w_hold_cnt_nxt = '0;
                w_core_rst_nxt = 1'b1;
                w_running_nxt  = 1'b0;
            end
        endcase
    end

    assign core_rst      = r_core_rst;
    assign running       = r_running;
    assign done          = r_done;
    assign halt_cause    = r_halt_cause;
    assign cycle_count   = r_cycle_count;
    assign instret_count = r_instret_count;

endmodule
`default_nettype wire

// File: tb/tb_core_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_run_controller
//  Description : Scoreboard bench for core_run_controller. Stimulus pushes
//                expected snapshots and halt reports into queues; a monitor
//                on the falling edge pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        retire;
    logic        ecall;
    logic        ext_stop;
    logic        core_rst;
    logic        running;
    logic        done;
    logic [2:0]  halt_cause;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    always #5 clk = ~clk;

    core_run_controller #(
        .RESET_CYCLES (2),
        .MAX_CYCLES   (20),
        .STALL_LIMIT  (4),
        .CNT_W        (32),
        .PC_W         (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc),
        .retire_i      (retire),
        .ecall_i       (ecall),
        .ext_stop_i    (ext_stop),
        .core_rst      (core_rst),
        .running       (running),
        .done          (done),
        .halt_cause    (halt_cause),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    typedef struct {
        int          tag;
        int          at;
        logic        core_rst;
        logic        running;
        logic        done;
        logic [2:0]  cause;
        logic [31:0] cyc;
        logic [31:0] inst;
    } exp_t;

    exp_t snap_q[$];
    exp_t halt_q[$];
    int   edges   = 0;
    int   n_total = 0;
    int   n_pass  = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) edges <= edges + 1;

    // One comparison of all observable outputs against an expected record.
    task automatic check(input string kind, input exp_t e);
        n_total++;
        if (core_rst === e.core_rst && running === e.running && done === e.done &&
            halt_cause === e.cause && cycle_count === e.cyc && instret_count === e.inst) begin
            n_pass++;
        end else begin
            $display("FAIL %s tag=%0d edge=%0d got core_rst=%b running=%b done=%b cause=%b cyc=%0d inst=%0d exp core_rst=%b running=%b done=%b cause=%b cyc=%0d inst=%0d",
                     kind, e.tag, edges, core_rst, running, done, halt_cause, cycle_count,
                     instret_count, e.core_rst, e.running, e.done, e.cause, e.cyc, e.inst);
        end
    endtask

    // Monitor: halt reports on a rising done, time-stamped snapshots otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (halt_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done edge=%0d got cause=%b cyc=%0d exp no halt",
                         edges, halt_cause, cycle_count);
            end else begin
                e = halt_q.pop_front();
                check("halt", e);
            end
        end
        prev_done <= done;
        while (snap_q.size() > 0 && snap_q[0].at <= edges) begin
            e = snap_q.pop_front();
            if (e.at < edges) begin
                n_total++;
                $display("FAIL missed_snap tag=%0d got edge=%0d exp edge=%0d", e.tag, edges, e.at);
            end else begin
                check("snap", e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int tag, input logic cr, input logic rn, input logic dn,
                                input logic [2:0] ca, input int cy, input int in);
        exp_t e;
        e.tag = tag; e.at = 0; e.core_rst = cr; e.running = rn; e.done = dn;
        e.cause = ca; e.cyc = 32'(cy); e.inst = 32'(in);
        return e;
    endfunction

    task automatic push_snap(input exp_t e);
        exp_t x;
        x = e;
        x.at = edges;
        snap_q.push_back(x);
    endtask

    task automatic clear_inputs();
        pc = 32'd0; retire = 1'b0; ecall = 1'b0; ext_stop = 1'b0;
    endtask

    // Hold reset for n edges with junk inputs; each edge leaves the reset state.
    task automatic assert_rst(input int tag, input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            pc = $urandom; retire = 1'b1; ecall = 1'b1; ext_stop = 1'b1;
            tick();
            push_snap(mk(tag, 1'b1, 1'b0, 1'b0, 3'b000, 0, 0));
        end
    endtask

    // Release reset; HOLD sees events that must be ignored.
    task automatic release_rst(input int tag);
        rst = 1'b0;
        pc = $urandom; retire = 1'b1; ecall = 1'b1; ext_stop = 1'b1;
        tick();
        push_snap(mk(tag, 1'b1, 1'b0, 1'b0, 3'b000, 0, 0));
        pc = $urandom;
        tick();
        push_snap(mk(tag, 1'b0, 1'b1, 1'b0, 3'b000, 0, 0));
        clear_inputs();
    endtask

    // Per-cycle stimulus for RUN cycle k (counted from 1) of each scenario.
    task automatic stim(input int scn, input int k, output logic [31:0] p,
                        output logic r, output logic ec, output logic ex);
        p = 32'(4 * (k - 1)); r = 1'b1; ec = 1'b0; ex = 1'b0;
        case (scn)
            1: begin
                if (k > 5) p = 32'd16;
                r = (k % 2 == 1);
            end
            2: begin
                if (k > 7) p = 32'd20;
                else if (k > 5) p = 32'd16;
            end
            3: begin
                r = 1'b0; ec = (k == 7); ex = (k == 7);
            end
            4: ec = (k == 20);
            default: ;
        endcase
    endtask

    // Drive a scenario until done rises or the cycle budget expires.
    task automatic run_scn(input int scn, input int tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            stim(scn, k, pc, retire, ecall, ext_stop);
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        clear_inputs();
        if (!seen) begin
            n_total++;
            $display("FAIL halt_timeout tag=%0d got done=%b exp done=1 within %0d cycles",
                     tag, done, budget);
        end
    endtask

    // DONE must ignore all inputs and hold every output.
    task automatic hold_done(input exp_t e, input int n);
        for (int i = 0; i < n; i++) begin
            pc = $urandom; retire = 1'b1; ecall = (i % 2 == 0); ext_stop = (i % 3 == 0);
            tick();
            push_snap(e);
        end
        clear_inputs();
    endtask

    task automatic scenario(input int scn, input int tag, input exp_t halt, input int stable);
        assert_rst(tag, 2);
        release_rst(tag);
        halt_q.push_back(halt);
        run_scn(scn, tag, 30);
        hold_done(halt, stable);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        // Reset release (3 reset edges) followed by timeout and a frozen DONE.
        assert_rst(1, 3);
        release_rst(1);
        halt_q.push_back(mk(1, 1'b1, 1'b0, 1'b1, 3'b100, 20, 20));
        run_scn(0, 1, 30);
        hold_done(mk(1, 1'b1, 1'b0, 1'b1, 3'b100, 20, 20), 10);

        // PC stall: held at 16 from cycle 6, fires at cycle 9; retire on odd cycles.
        scenario(1, 2, mk(2, 1'b1, 1'b0, 1'b1, 3'b010, 9, 5), 3);
        // PC change at cycle 8 restarts the stall window; fires at cycle 12.
        scenario(2, 3, mk(3, 1'b1, 1'b0, 1'b1, 3'b010, 12, 12), 3);
        // ecall and ext stop together at cycle 7: ext stop wins.
        scenario(3, 4, mk(4, 1'b1, 1'b0, 1'b1, 3'b011, 7, 0), 3);
        // ecall in the timeout cycle: ecall wins.
        scenario(4, 5, mk(5, 1'b1, 1'b0, 1'b1, 3'b001, 20, 20), 3);

        // Mid-run reset at cycle 10, then a fresh run that times out.
        assert_rst(6, 1);
        release_rst(6);
        for (int k = 1; k <= 9; k++) begin
            stim(0, k, pc, retire, ecall, ext_stop);
            tick();
        end
        stim(0, 10, pc, retire, ecall, ext_stop);
        rst = 1'b1;
        tick();
        push_snap(mk(6, 1'b1, 1'b0, 1'b0, 3'b000, 0, 0));
        assert_rst(6, 1);
        release_rst(6);
        halt_q.push_back(mk(6, 1'b1, 1'b0, 1'b1, 3'b100, 20, 20));
        run_scn(0, 6, 30);
        hold_done(mk(6, 1'b1, 1'b0, 1'b1, 3'b100, 20, 20), 2);

        tick();
        tick();
        while (snap_q.size() > 0) begin
            exp_t e;
            e = snap_q.pop_front();
            n_total++;
            $display("FAIL unchecked_snap tag=%0d got none exp edge=%0d", e.tag, e.at);
        end
        while (halt_q.size() > 0) begin
            exp_t e;
            e = halt_q.pop_front();
            n_total++;
            $display("FAIL unchecked_halt tag=%0d got none exp cause=%b", e.tag, e.cause);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog got no finish exp finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
